// File: rtl/tmds_fabric_serializer_if.sv
// Word-level handshake into the TMDS serializer: one LANES x DATA_WIDTH word per
// in_valid/in_ready transfer. The encoder side drives through master.
interface tmds_fabric_serializer_if #(
  parameter int LANES      = 3,
  parameter int DATA_WIDTH = 10
);
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tmds_fabric_serializer.sv
// Multi-lane fabric serializer for the TMDS path: word FIFO, start/drain FSM,
// LSB-first beat emission, idle-word insertion and underflow telemetry.
module tmds_fabric_serializer #(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    LANES        = 3,
  parameter int                    BITS_PER_CLK = 2,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD    = DATA_WIDTH'(10'b1101010100)
) (
  input  logic                            serial_clk,
  input  logic                            rst_n,
  input  logic                            i_enable,
  tmds_fabric_serializer_if.slave         s_in,
  output logic [LANES*BITS_PER_CLK-1:0]   o_ser_out,
  output logic                            o_word_start,
  output logic                            o_underflow,
  output logic [15:0]                     o_underflow_cnt
);

  localparam int BEATS = DATA_WIDTH / BITS_PER_CLK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW    = LANES * DATA_WIDTH;
  localparam int SW    = LANES * BITS_PER_CLK;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          r_state;
  logic [BW-1:0]   r_beat_cnt;
  logic            r_primed;
  logic            r_rdy_en;
  logic [WW-1:0]   r_shift;

  logic [WW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_decision;
  logic            w_finish;
  logic [WW-1:0]   w_load_word;
  logic [WW-1:0]   w_shift_load;
  logic [WW-1:0]   w_shift_adv;
  logic [SW-1:0]   w_first_beat;
  logic [SW-1:0]   w_next_beat;

  // in_ready depends only on registered state; r_rdy_en holds it low through reset.
  assign w_full        = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign s_in.in_ready = r_rdy_en & ~w_full;
  assign w_push        = s_in.in_valid & s_in.in_ready;

  assign w_decision = i_enable &
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_RUN) && (r_beat_cnt == LAST_BEAT)));
  assign w_pop      = w_decision & ~w_empty;
  assign w_finish   = (r_beat_cnt == LAST_BEAT) &&
                      ((r_state == ST_DRAIN) || ((r_state == ST_RUN) && !i_enable));

  assign w_load_word = w_empty ? {LANES{IDLE_WORD}} : r_mem[r_rd_ptr];

  always_comb begin
    w_first_beat = '0;
    w_next_beat  = '0;
    w_shift_load = '0;
    w_shift_adv  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_first_beat[l*BITS_PER_CLK +: BITS_PER_CLK] = w_load_word[l*DATA_WIDTH +: BITS_PER_CLK];
      w_next_beat[l*BITS_PER_CLK +: BITS_PER_CLK]  = r_shift[l*DATA_WIDTH +: BITS_PER_CLK];
      w_shift_load[l*DATA_WIDTH +: DATA_WIDTH] = w_load_word[l*DATA_WIDTH +: DATA_WIDTH] >> BITS_PER_CLK;
      w_shift_adv[l*DATA_WIDTH +: DATA_WIDTH]  = r_shift[l*DATA_WIDTH +: DATA_WIDTH] >> BITS_PER_CLK;
    end
  end

  // FIFO storage and the beat shifter carry no reset; pointers and count gate their use.
  always_ff @(posedge serial_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_in.in_data;
    end
    r_shift <= w_decision ? w_shift_load : w_shift_adv;
  end

  always_ff @(posedge serial_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Control FSM; ser_out is already registered, so beat 0 shows the cycle after its load decision.
  always_ff @(posedge serial_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_beat_cnt      <= '0;
      r_primed        <= 1'b0;
      o_ser_out       <= '0;
      o_word_start    <= 1'b0;
      o_underflow     <= 1'b0;
      o_underflow_cnt <= '0;
    end else begin
      o_word_start <= 1'b0;
      o_underflow  <= 1'b0;

      case (r_state)
        ST_IDLE:  if (i_enable) r_state <= ST_RUN;
        ST_RUN:   if (!i_enable) r_state <= (r_beat_cnt == LAST_BEAT) ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: if (r_beat_cnt == LAST_BEAT) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      if (w_decision) begin
        o_ser_out    <= w_first_beat;
        r_beat_cnt   <= '0;
        o_word_start <= 1'b1;
        if (w_empty) begin
          // Idle fill before the first real word is expected, so it is not counted.
          if (r_primed) begin
            o_underflow     <= 1'b1;
            o_underflow_cnt <= sat_inc16(o_underflow_cnt);
          end
        end else begin
          r_primed <= 1'b1;
        end
      end else if (w_finish || (r_state == ST_IDLE)) begin
        o_ser_out  <= '0;
        r_beat_cnt <= '0;
        if (w_finish) begin
          r_primed <= 1'b0;
        end
      end else begin
        o_ser_out  <= w_next_beat;
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tmds_fabric_serializer.sv
// Directed bench for tmds_fabric_serializer (3 lanes x 10 bits, DDR pairs, 4-deep FIFO).
module tb_tmds_fabric_serializer;

  logic        serial_clk = 1'b0;
  logic        rst_n      = 1'b0;
  logic        i_enable   = 1'b0;
  logic [5:0]  o_ser_out;
  logic        o_word_start;
  logic        o_underflow;
  logic [15:0] o_underflow_cnt;

  int tests = 0;
  int fails = 0;

  tmds_fabric_serializer_if #(.LANES(3), .DATA_WIDTH(10)) bus ();

  tmds_fabric_serializer #(
    .DATA_WIDTH(10), .LANES(3), .BITS_PER_CLK(2), .FIFO_DEPTH(4),
    .IDLE_WORD(10'b1101010100)
  ) dut (
    .serial_clk      (serial_clk),
    .rst_n           (rst_n),
    .i_enable        (i_enable),
    .s_in            (bus),
    .o_ser_out       (o_ser_out),
    .o_word_start    (o_word_start),
    .o_underflow     (o_underflow),
    .o_underflow_cnt (o_underflow_cnt)
  );

  always #5 serial_clk = ~serial_clk;

  // Beats of IDLE_WORD 10'b1101010100, LSB pair first, replicated on all 3 lanes.
  logic [5:0] idle_exp [5] = '{6'b000000, 6'b010101, 6'b010101, 6'b010101, 6'b111111};

  function automatic logic [5:0] exp_beat(input logic [29:0] w, input int k);
    logic [5:0] r;
    r = '0;
    for (int l = 0; l < 3; l++) r[l*2 +: 2] = w[l*10 + 2*k +: 2];
    return r;
  endfunction

  task automatic tick();
    @(posedge serial_clk);
    #1;
  endtask

  task automatic push_idle(input logic [29:0] w);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) tick();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL rst_ser_out got %b want 000000", o_ser_out); end
    tests++; if (o_word_start !== 1'b0 || o_underflow !== 1'b0) begin fails++; $display("FAIL rst_flags got ws=%b uf=%b want 0/0", o_word_start, o_underflow); end
    tests++; if (o_underflow_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d want 0", o_underflow_cnt); end
    rst_n = 1'b1;
    tick();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready got %b want 1", bus.in_ready); end
    tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL rel_ser_out got %b want 000000", o_ser_out); end
  endtask

  task automatic test_single_word();
    push_idle({10'h155, 10'h000, 10'h3FF});
    i_enable = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tests++; if (o_ser_out !== 6'b010011) begin fails++; $display("FAIL single_beat%0d got %b want 010011", k, o_ser_out); end
      tests++; if (o_word_start !== (k == 0)) begin fails++; $display("FAIL single_ws%0d got %b want %b", k, o_word_start, k == 0); end
      if (k == 4) i_enable = 1'b0;
      tick();
    end
    tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL single_idle got %b want 000000", o_ser_out); end
    tests++; if (o_underflow_cnt !== 16'd0) begin fails++; $display("FAIL single_cnt got %0d want 0", o_underflow_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] wv [8];
    int idx = 0;
    bit saw_full = 1'b0;
    for (int j = 0; j < 8; j++) wv[j] = {10'(j*37 + 1), 10'(j*91 + 5), 10'(1023 - j*53)};
    fork
      begin
        int guard = 0;
        logic rdy;
        bus.in_data = wv[0]; bus.in_valid = 1'b1;
        while (idx < 8 && guard < 200) begin
          @(negedge serial_clk);
          rdy = bus.in_ready;
          if (!rdy) saw_full = 1'b1;
          tick();
          if (rdy) begin
            idx++;
            if (idx < 8) bus.in_data = wv[idx];
          end
          guard++;
        end
        bus.in_valid = 1'b0;
      end
      begin
        tick();
        i_enable = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
          for (int k = 0; k < 5; k++) begin
            tests++; if (o_ser_out !== exp_beat(wv[j], k)) begin fails++; $display("FAIL b2b_w%0d_b%0d got %b want %b", j, k, o_ser_out, exp_beat(wv[j], k)); end
            tests++; if (o_word_start !== (k == 0)) begin fails++; $display("FAIL b2b_ws_w%0d_b%0d got %b want %b", j, k, o_word_start, k == 0); end
            tests++; if (o_underflow !== 1'b0) begin fails++; $display("FAIL b2b_uf_w%0d_b%0d got %b want 0", j, k, o_underflow); end
            if (j == 7 && k == 4) i_enable = 1'b0;
            tick();
          end
        end
        tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL b2b_end got %b want 000000", o_ser_out); end
      end
    join
    tests++; if (idx !== 8) begin fails++; $display("FAIL b2b_pushed got %0d want 8", idx); end
    tests++; if (saw_full !== 1'b1) begin fails++; $display("FAIL b2b_backpressure got %b want 1", saw_full); end
    tests++; if (o_underflow_cnt !== 16'd0) begin fails++; $display("FAIL b2b_cnt got %0d want 0", o_underflow_cnt); end
  endtask

  task automatic test_underflow();
    logic [29:0] a;
    a = {10'h30C, 10'h0F0, 10'h2AA};
    push_idle(a);
    i_enable = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tests++; if (o_ser_out !== exp_beat(a, k)) begin fails++; $display("FAIL uf_prime_b%0d got %b want %b", k, o_ser_out, exp_beat(a, k)); end
      tick();
    end
    for (int n = 1; n <= 3; n++) begin
      for (int k = 0; k < 5; k++) begin
        tests++; if (o_ser_out !== idle_exp[k]) begin fails++; $display("FAIL uf_idle%0d_b%0d got %b want %b", n, k, o_ser_out, idle_exp[k]); end
        tests++; if (o_underflow !== (k == 0)) begin fails++; $display("FAIL uf_pulse%0d_b%0d got %b want %b", n, k, o_underflow, k == 0); end
        tests++; if (o_word_start !== (k == 0)) begin fails++; $display("FAIL uf_ws%0d_b%0d got %b want %b", n, k, o_word_start, k == 0); end
        tests++; if (o_underflow_cnt !== 16'(n)) begin fails++; $display("FAIL uf_cnt%0d_b%0d got %0d want %0d", n, k, o_underflow_cnt, n); end
        if (n == 3 && k == 4) i_enable = 1'b0;
        tick();
      end
    end
    tests++; if (o_ser_out !== 6'd0 || o_underflow !== 1'b0) begin fails++; $display("FAIL uf_end got ser=%b uf=%b want 000000/0", o_ser_out, o_underflow); end
    tests++; if (o_underflow_cnt !== 16'd3) begin fails++; $display("FAIL uf_final_cnt got %0d want 3", o_underflow_cnt); end
  endtask

  task automatic test_drain();
    logic [29:0] dw [3];
    dw[0] = {10'h2C1, 10'h13E, 10'h0A5};
    dw[1] = {10'h3C3, 10'h055, 10'h1F0};
    dw[2] = {10'h00F, 10'h2AA, 10'h381};
    for (int i = 0; i < 3; i++) push_idle(dw[i]);
    i_enable = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tests++; if (o_ser_out !== exp_beat(dw[0], k)) begin fails++; $display("FAIL drain_w0_b%0d got %b want %b", k, o_ser_out, exp_beat(dw[0], k)); end
      if (k == 2) i_enable = 1'b0;
      if (k == 3) i_enable = 1'b1;
      tick();
    end
    tests++; if (o_ser_out !== 6'd0 || o_word_start !== 1'b0) begin fails++; $display("FAIL drain_idle got ser=%b ws=%b want 000000/0", o_ser_out, o_word_start); end
    tick();
    for (int j = 1; j < 3; j++) begin
      for (int k = 0; k < 5; k++) begin
        tests++; if (o_ser_out !== exp_beat(dw[j], k)) begin fails++; $display("FAIL drain_w%0d_b%0d got %b want %b", j, k, o_ser_out, exp_beat(dw[j], k)); end
        tests++; if (o_word_start !== (k == 0)) begin fails++; $display("FAIL drain_ws_w%0d_b%0d got %b want %b", j, k, o_word_start, k == 0); end
        if (j == 2 && k == 4) i_enable = 1'b0;
        tick();
      end
    end
    tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL drain_end got %b want 000000", o_ser_out); end
    tests++; if (o_underflow_cnt !== 16'd3) begin fails++; $display("FAIL drain_cnt got %0d want 3", o_underflow_cnt); end
  endtask

  task automatic test_full();
    logic [29:0] fw [5];
    for (int i = 0; i < 5; i++) fw[i] = {10'(100*i + 7), 10'(1000 - 77*i), 10'(33*i + 300)};
    i_enable = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = fw[i];
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_before%0d got %b want 1", i, bus.in_ready); end
      tick();
    end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", bus.in_ready); end
    bus.in_data = fw[4];
    tick();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_refuse got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    i_enable = 1'b1;
    tick();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after got %b want 1", bus.in_ready); end
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 5; k++) begin
        tests++; if (o_ser_out !== exp_beat(fw[j], k)) begin fails++; $display("FAIL full_w%0d_b%0d got %b want %b", j, k, o_ser_out, exp_beat(fw[j], k)); end
        if (j == 3 && k == 4) i_enable = 1'b0;
        tick();
      end
    end
    tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL full_end got %b want 000000", o_ser_out); end
    tests++; if (o_underflow_cnt !== 16'd3 || o_underflow !== 1'b0) begin fails++; $display("FAIL full_uf got cnt=%0d uf=%b want 3/0", o_underflow_cnt, o_underflow); end
  endtask

  task automatic test_reset_mid();
    logic [29:0] r;
    r = {10'h3A5, 10'h15A, 10'h2F3};
    push_idle(r);
    i_enable = 1'b1;
    tick();
    repeat (3) tick();
    tests++; if (o_ser_out !== exp_beat(r, 3)) begin fails++; $display("FAIL rmid_b3 got %b want %b", o_ser_out, exp_beat(r, 3)); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL rmid_ser got %b want 000000", o_ser_out); end
    tests++; if (o_underflow_cnt !== 16'd0) begin fails++; $display("FAIL rmid_cnt got %0d want 0", o_underflow_cnt); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready got %b want 0", bus.in_ready); end
    i_enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_rel got %b want 1", bus.in_ready); end
    for (int c = 0; c < 4; c++) begin
      tests++; if (o_ser_out !== 6'd0 || o_word_start !== 1'b0) begin fails++; $display("FAIL rmid_quiet%0d got ser=%b ws=%b want 000000/0", c, o_ser_out, o_word_start); end
      tick();
    end
    i_enable = 1'b1;
    tick();
    tests++; if (o_ser_out !== idle_exp[0] || o_word_start !== 1'b1) begin fails++; $display("FAIL rmid_restart got ser=%b ws=%b want %b/1", o_ser_out, o_word_start, idle_exp[0]); end
    tests++; if (o_underflow !== 1'b0) begin fails++; $display("FAIL rmid_uf got %b want 0", o_underflow); end
    i_enable = 1'b0;
    for (int k = 1; k < 5; k++) begin
      tick();
      tests++; if (o_ser_out !== idle_exp[k]) begin fails++; $display("FAIL rmid_idle_b%0d got %b want %b", k, o_ser_out, idle_exp[k]); end
    end
    tick();
    tests++; if (o_ser_out !== 6'd0) begin fails++; $display("FAIL rmid_end got %b want 000000", o_ser_out); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underflow();
    test_drain();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tmds_fabric_serializer.md
Name: tmds_fabric_serializer

Overview:
- Parametrised, primitive-free, multi-lane parallel-to-serial serializer for the HDMI TMDS path. Runs entirely in the serial clock domain.
- Accepts one LANES×DATA_WIDTH word per valid/ready handshake into a small FIFO and emits BITS_PER_CLK bits per lane per cycle, LSB first.
- Sits between the TMDS encoders and the output pads (DDR/ODDR or OBUFDS).
- Adds a start/drain state machine, idle-word insertion on underflow, and underflow telemetry.

Parameters:
- DATA_WIDTH, 10, bits per lane word; must be a multiple of BITS_PER_CLK.
- LANES, 3, number of independent serial lanes (TMDS channels).
- BITS_PER_CLK, 2, bits emitted per lane per clock (1 = SDR, 2 = DDR pair).
- FIFO_DEPTH, 4, word FIFO entries; power of two, ≥2.
- IDLE_WORD, 10'b1101010100, word loaded into every lane on underflow.

Ports:
- serial_clk  in  1  bit/beat clock; all logic on rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- enable  in  1  1 = run serializer; 0 = finish current word, then idle.
- in_data  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  word valid.
- in_ready  out  1  FIFO not full.
- ser_out  out  LANES*BITS_PER_CLK  registered serial bits; lane i at [i*BITS_PER_CLK +: BITS_PER_CLK].
- word_start  out  1  high on the cycle ser_out carries beat 0 of a word.
- underflow  out  1  one-cycle pulse when IDLE_WORD is loaded due to an empty FIFO.
- underflow_cnt  out  16  saturating count of underflow pulses.

Behaviour:
- BEATS = DATA_WIDTH/BITS_PER_CLK. beat_cnt runs 0..BEATS-1 and wraps. At beat k, lane bits [k*B +: B] are driven; the lower index is transmitted first.
- Reset (rst_n low, asynchronous): state=IDLE; FIFO empty; beat_cnt=0; ser_out=0; word_start=0; underflow=0; underflow_cnt=0; primed=0; in_ready=0 while reset is asserted, 1 from the first cycle after release.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full, computed from registered state; no pass-through when full, even with a simultaneous pop.
  - A push and a pop in the same cycle are both honoured.
  - No bypass: a word pushed in a load-decision cycle is not eligible until the next decision.
  - Retained across IDLE/DRAIN.
- States:
  - IDLE: ser_out=0, beat_cnt held at 0, no pops. Go to RUN when enable=1; that cycle is a load decision.
  - RUN: a load decision occurs when beat_cnt==BEATS-1 and on RUN entry.
    - FIFO non-empty: pop into the shift register and set primed=1.
    - FIFO empty: load IDLE_WORD into all lanes. If primed=1, pulse underflow and increment underflow_cnt (saturating at 16'hFFFF).
    - enable=0 in any RUN cycle → DRAIN. The current word completes; no further load.
  - DRAIN: continue beats until beat_cnt==BEATS-1 is output, then go to IDLE and clear primed. enable re-asserted during DRAIN is ignored until IDLE.
- Latency: beat 0 of a loaded word appears on ser_out the cycle after its load decision, with word_start=1. Output is continuous, with no gap between words in RUN.
- underflow is asserted in the same cycle as the word_start of the idle word.
- Reset mid-word aborts immediately. No partial word is emitted after release.
- All lanes share beat_cnt and are always word-aligned.

Test Plan:
- Reset, enable=1, push one word (lanes 10'h3FF/10'h000/10'h155) → after the load, 5 cycles of ser_out per lane: lane0 2'b11 ×5, lane1 2'b00 ×5, lane2 2'b01 ×5; word_start high on beat 0 only.
- Stream 8 back-to-back words with in_valid held high → in_ready toggles to keep the FIFO ≤4, 40 contiguous beats with no gap, underflow never asserted.
- Prime with 1 word, then starve → the next boundary loads 10'b1101010100 on all lanes, underflow pulses once per idle word, underflow_cnt = 3 after 3 empty decisions.
- Deassert enable at beat 2 of a word → beats 3 and 4 are still emitted, then ser_out=0 and the IDLE state is reached; the FIFO keeps 2 queued words, which emit first after re-enable.
- Fill the FIFO (4 words) with enable=0 → in_ready=0, a 5th push is refused; raise enable → the words are emitted in order, then in_ready returns to 1.
- Assert rst_n low at beat 3 → ser_out=0, underflow_cnt=0, and in_ready=0 immediately (asynchronous); after release, in_ready=1 and no residual bits appear.
